// File: rtl/key_debounce_pkg.sv
// Shared constants, width helpers and the per-channel event bundle for the key debouncer.
package key_debounce_pkg;

  localparam int DEB_STABLE_DEF = 15;
  localparam int DEB_HOLD_DEF   = 1000;

  // Counter width able to hold the value n (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEB_CNT_W_DEF  = $clog2(DEB_STABLE_DEF + 1);
  localparam int DEB_HCNT_W_DEF = $clog2(DEB_HOLD_DEF + 1);

  // "release" is a reserved word, hence the short field name.
  typedef struct packed {
    logic press;
    logic rel;
    logic hold;
  } deb_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: optional 2-flop synchroniser (KEY_DEBOUNCE_SYNC_EN), stability
// counter, debounced level, hold counter and registered press/release/hold pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE     = DEB_STABLE_DEF,
  parameter int HOLD       = DEB_HOLD_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     raw,
  output logic     level,
  output deb_evt_t evt
);

  localparam int CW = cnt_w(STABLE);
  localparam int HW = cnt_w(HOLD);
  localparam logic [CW-1:0] CMAX  = CW'(STABLE - 1);
  localparam logic [HW-1:0] HMAX  = HW'(HOLD);
  localparam logic [HW-1:0] HFIRE = HW'(HOLD - 1);

  logic          smp;
  logic          s;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;

`ifdef KEY_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], raw};
  end

  assign smp = sync_q[1];
`else
  assign smp = raw;
`endif

  // Polarity is applied after the synchroniser so the sync flops reset to 0 either way.
  assign s = (ACTIVE_LOW != 0) ? ~smp : smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      hcnt  <= '0;
      level <= 1'b0;
      evt   <= '0;
    end else begin
      evt <= '0;

      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        level     <= s;
        cnt       <= '0;
        evt.press <= s;
        evt.rel   <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A press commit happens while level is still 0, so this also clears hcnt then.
      if (!level) begin
        hcnt <= '0;
      end else if (hcnt != HMAX) begin
        hcnt     <= hcnt + 1'b1;
        evt.hold <= (hcnt == HFIRE);
      end
    end
  end

endmodule

// File: rtl/key_debounce_mc.sv
// Multi-channel key debouncer: CH independent channels plus a combinational 'changed' flag.
// Define KEY_DEBOUNCE_SYNC_EN to add a 2-flop synchroniser (+2 cycles) on every input.
module key_debounce_mc
  import key_debounce_pkg::*;
#(
  parameter int CH         = 4,
  parameter int STABLE     = DEB_STABLE_DEF,
  parameter int HOLD       = DEB_HOLD_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel,
  output logic [CH-1:0] hold,
  output logic          changed
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    deb_evt_t evt;

    key_debounce_ch #(
      .STABLE    (STABLE),
      .HOLD      (HOLD),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (in[g]),
      .level(level[g]),
      .evt  (evt)
    );

    assign press[g] = evt.press;
    assign rel[g]   = evt.rel;
    assign hold[g]  = evt.hold;
  end

  assign changed = |(press | rel);

endmodule

// File: doc/key_debounce_mc.md
# key_debounce_mc

Multi-channel, parametrised input debouncer for mechanical keys and switches on the board I/O path, placed between the raw pads and the control logic. Each channel has its own stability counter and holds a clean debounced level. Each channel emits single-cycle press, release and long-hold pulses. The block replaces per-key single-channel debouncers that could only report a press edge.

## Interface
Parameters:
- CH, 4, number of independent channels.
- STABLE, 15, consecutive differing samples required to commit a new level (≥1).
- HOLD, 1000, cycles the debounced level must stay active after a press before `hold` fires (≥1).
- ACTIVE_LOW, 0, 1 = raw input is active-low (inverted before debouncing).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- in  in  CH  raw key inputs.
- level  out  CH  debounced active level (1 = pressed).
- press  out  CH  one-cycle pulse when `level` goes 0→1.
- release  out  CH  one-cycle pulse when `level` goes 1→0.
- hold  out  CH  one-cycle pulse, once per press, after HOLD active cycles.
- changed  out  1  OR of all `press` and `release` bits.

## Operation
- Sample s[i] = in[i] XOR ACTIVE_LOW, after the optional synchroniser.
- Per channel: counter `cnt` of width clog2(STABLE+1) and register `level`.
  - s == level: cnt ← 0.
  - s != level and cnt == STABLE-1: level ← s, cnt ← 0, and the matching pulse is registered: `press` if s=1, `release` if s=0.
  - Otherwise: cnt ← cnt+1.
- A single agreeing sample in the middle of a count (a glitch) clears cnt. Qualification restarts from zero.
- STABLE=1: level follows s with one cycle of latency, and every committed change pulses.
- Hold counter `hcnt`, width clog2(HOLD+1):
  - Cleared while level=0 and on the press commit.
  - Increments while level=1, saturating at HOLD.
  - `hold` pulses on the cycle hcnt becomes HOLD, so it fires exactly once per press with no auto-repeat.
  - A release before HOLD produces no `hold`.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.
- `changed` is a combinational OR of registered pulses and carries no extra latency.
- Reset (any time, including mid-count): cnt, hcnt, level, press, release, hold, and the sync flops all go to 0. After reset, a key already held active must requalify in full and then produces a `press`.

## Timing
- All outputs are registered except `changed`, and all are 0 in reset.
- Without sync:
  - in[i] becomes active before edge e0 and stays stable.
  - level[i] and press[i] go high after edge e0+STABLE-1.
  - press[i] drops after the next edge.
- With sync, add 2 cycles.
- `hold` rises HOLD edges after the edge that raised `level`.
- `press` and `release` are never both high on one channel in the same cycle.
- The minimum spacing between a press and a release on one channel is STABLE cycles.

## Configuration
- `KEY_DEBOUNCE_SYNC_EN` defined: each in[i] passes through a 2-flop synchroniser (reset to 0, before polarity inversion), adding 2 cycles of latency.
- Macro undefined: `in` is sampled directly. This is for inputs already synchronous to clk; the latency figures in Timing apply as stated.

## Structure
- Package `key_debounce_pkg`:
  - Default constants DEB_STABLE_DEF=15 and DEB_HOLD_DEF=1000.
  - Width helper constants.
  - Per-channel event typedef with fields press, release, hold.
- Sub-module `key_debounce_ch`: one channel (sync option, counter, level, hold counter, pulses), instantiated CH times in a generate loop. The top level builds `changed`.

## Test plan
(CH=4, STABLE=15, HOLD=100, ACTIVE_LOW=0, sync disabled unless noted)
- Reset: rst_n=0 with in=4'hF, then rst_n=1 at edge 0 → all outputs 0 during reset; level=4'hF and press=4'hF for one cycle after edge 14; changed=1 for that one cycle.
- Bounce: in[1] toggles every 3 cycles for 30 cycles, then holds at 1 → no press during the bounce; press[1] after the 15th edge following the final rise.
- Release glitch: with level[0]=1, in[0]=0 for 14 cycles, 1 for 1 cycle, then 0 → no release at 14; release[0] 15 edges after the final fall.
- Hold: in[2]=1 held 250 cycles → a single hold[2] pulse 100 edges after press[2]; a second run released at 60 cycles → no hold.
- Simultaneous: press qualifying on ch0 and release on ch3 at the same edge → press[0]=release[3]=1 in the same cycle; changed=1 for exactly one cycle.
- Reset mid-count plus sync: with the macro defined, apply rst_n=0 at count 10 → everything 0; after release, press appears 17 edges after the input is stable.
